// File: rtl/otter_csr_int_pkg.sv
// rtl/otter_csr_int_pkg.sv - shared constants, state type and CSR op helper
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS    = 12'h300;
  localparam logic [11:0] CSR_MTVEC      = 12'h305;
  localparam logic [11:0] CSR_MEPC       = 12'h341;
  localparam logic [11:0] CSR_MCAUSE     = 12'h342;
  localparam logic [6:0]  OP_SYSTEM      = 7'b1110011;
  localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;
  localparam logic [31:0] ALIGN4_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {IDLE, TAKEN} int_state_t;

  // funct3[1:0]: 1 = write, 2 = set, 3 = clear
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wd);
    logic [31:0] res;
    case (op)
      2'd1:    res = wd;
      2'd2:    res = old_val | wd;
      2'd3:    res = old_val & ~wd;
      default: res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/otter_csr_int_if.sv
// rtl/otter_csr_int_if.sv - commit-side bus between the core and the CSR block
interface otter_csr_int_if;

  logic        INSTR_VALID;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  FUNC3;
  logic [11:0] CSR_ADDR;
  logic [31:0] WD;
  logic [31:0] NEXT_PC;
  logic [31:0] RD;
  logic [31:0] MTVEC;
  logic [31:0] MEPC;
  logic        MIE;
  logic        INT_TAKEN;

  modport master (
    output INSTR_VALID, CU_OPCODE, FUNC3, CSR_ADDR, WD, NEXT_PC,
    input  RD, MTVEC, MEPC, MIE, INT_TAKEN
  );

  modport slave (
    input  INSTR_VALID, CU_OPCODE, FUNC3, CSR_ADDR, WD, NEXT_PC,
    output RD, MTVEC, MEPC, MIE, INT_TAKEN
  );

endinterface

// File: rtl/otter_csr_int_sync_edge.sv
// rtl/otter_csr_int_sync_edge.sv - multi-flop synchroniser with rising-edge pulse
module int_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // Edge flop resets low, so a level held through reset yields one fresh edge.
  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/otter_csr_int.sv
// rtl/otter_csr_int.sv - machine-mode CSR file and external-interrupt trap FSM
module otter_csr_int
  import otter_csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           INTR,
  otter_csr_int_if.slave bus
);

  int_state_t  state_q, state_d;
  logic        mie_q, mie_d, mpie_q, mpie_d, pending_q, pending_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] rd_val, wr_val;
  logic        intr_rise, commit_sys, csr_wr, mret, mie_next, trap;

  int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (CLK),
    .rst      (RST),
    .async_in (INTR),
    .rise     (intr_rise)
  );

  always_comb begin
    case (bus.CSR_ADDR)
      CSR_MSTATUS: rd_val = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CSR_MTVEC:   rd_val = mtvec_q;
      CSR_MEPC:    rd_val = mepc_q;
      CSR_MCAUSE:  rd_val = mcause_q;
      default:     rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    pending_d = pending_q | intr_rise;

    // The pipeline is flushing in TAKEN, so commits there have no effect.
    commit_sys = bus.INSTR_VALID && (state_q == IDLE) && (bus.CU_OPCODE == OP_SYSTEM);
    csr_wr     = commit_sys && (bus.FUNC3[1:0] != 2'b00);
    mret       = commit_sys && (bus.FUNC3 == 3'b000);
    wr_val     = csr_apply(bus.FUNC3[1:0], rd_val, bus.WD);

    if (csr_wr) begin
      case (bus.CSR_ADDR)
        CSR_MSTATUS: begin
          mie_d  = wr_val[3];
          mpie_d = wr_val[7];
        end
        CSR_MTVEC: mtvec_d = wr_val & ALIGN4_MASK;
        CSR_MEPC:  mepc_d  = wr_val & ALIGN4_MASK;
        default: ;
      endcase
    end

    if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    // A commit that enables MIE can itself be the point where the trap is taken.
    mie_next = mie_d;
    trap     = (state_q == IDLE) && pending_q && bus.INSTR_VALID && mie_next;

    case (state_q)
      IDLE: begin
        if (trap) begin
          state_d   = TAKEN;
          mepc_d    = bus.NEXT_PC & ALIGN4_MASK;
          mpie_d    = mie_next;
          mie_d     = 1'b0;
          mcause_d  = MCAUSE_EXT_INT;
          pending_d = intr_rise;
        end
      end
      TAKEN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      mtvec_q   <= MTVEC_RST & ALIGN4_MASK;
      mepc_q    <= 32'd0;
      mcause_q  <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      pending_q <= pending_d;
    end
  end

  assign bus.RD        = rd_val;
  assign bus.MTVEC     = mtvec_q;
  assign bus.MEPC      = mepc_q;
  assign bus.MIE       = mie_q;
  assign bus.INT_TAKEN = (state_q == TAKEN);

endmodule

// File: tb/tb_otter_csr_int.sv
// tb/tb_otter_csr_int.sv - directed scoreboard bench for otter_csr_int
module tb_otter_csr_int;
  import otter_csr_pkg::*;

  localparam logic [31:0] RSTV   = 32'h0000_0100;
  localparam logic [6:0]  OP_ALU = 7'b0010011;
  localparam int SEL_RD = 0, SEL_MTVEC = 1, SEL_MEPC = 2, SEL_MIE = 3, SEL_TAKEN = 4, SEL_MEAS = 5;

  logic CLK = 1'b0;
  logic RST;
  logic INTR;

  otter_csr_int_if bus ();

  otter_csr_int #(.MTVEC_RST(RSTV), .SYNC_STAGES(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .INTR (INTR),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] meas;
  int          n;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD:    return bus.RD;
      SEL_MTVEC: return bus.MTVEC;
      SEL_MEPC:  return bus.MEPC;
      SEL_MIE:   return {31'd0, bus.MIE};
      SEL_TAKEN: return {31'd0, bus.INT_TAKEN};
      default:   return meas;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_t         e;
    logic [31:0] o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    bus.INSTR_VALID = 1'b0;
    bus.CU_OPCODE   = OP_ALU;
    bus.FUNC3       = 3'd0;
    bus.CSR_ADDR    = 12'd0;
    bus.WD          = 32'd0;
  endtask

  task automatic commit(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] wd);
    bus.INSTR_VALID = 1'b1;
    bus.CU_OPCODE   = OP_SYSTEM;
    bus.FUNC3       = f3;
    bus.CSR_ADDR    = addr;
    bus.WD          = wd;
    tick();
    idle_in();
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    bus.CSR_ADDR = addr;
    push(tag, SEL_RD, exp);
    #1;
    drain();
  endtask

  task automatic count_traps(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      tick();
      if (bus.INT_TAKEN) cnt++;
    end
  endtask

  task automatic wait_taken(input int bound, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.INT_TAKEN && cyc < bound);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1;
    INTR = 1'b0;
    bus.NEXT_PC = 32'd0;
    idle_in();

    // Reset
    repeat (2) tick();
    RST = 1'b0;
    push("rst_mtvec", SEL_MTVEC, RSTV);
    push("rst_taken", SEL_TAKEN, 32'd0);
    push("rst_mie", SEL_MIE, 32'd0);
    drain();
    rd_chk("rst_mstatus", CSR_MSTATUS, 32'd0);
    rd_chk("rst_mepc", CSR_MEPC, 32'd0);
    rd_chk("rst_mcause", CSR_MCAUSE, 32'd0);

    // CSR ops; RD shows the pre-write value during the commit cycle
    rd_chk("rd_prewrite", CSR_MTVEC, RSTV);
    commit(3'd1, CSR_MTVEC, 32'h0000_1003);
    push("csrrw_mtvec", SEL_MTVEC, 32'h0000_1000);
    drain();
    rd_chk("rd_mtvec", CSR_MTVEC, 32'h0000_1000);
    commit(3'd2, CSR_MSTATUS, 32'd8);
    push("csrrs_mie", SEL_MIE, 32'd1);
    drain();
    rd_chk("rd_mstatus_set", CSR_MSTATUS, 32'h0000_0008);
    commit(3'd3, CSR_MSTATUS, 32'd8);
    push("csrrc_mie", SEL_MIE, 32'd0);
    drain();
    commit(3'd1, 12'h7C0, 32'hFFFF_FFFF);
    rd_chk("rd_unimpl", 12'h7C0, 32'd0);
    push("unimpl_mtvec", SEL_MTVEC, 32'h0000_1000);
    drain();
    commit(3'd1, CSR_MCAUSE, 32'h1234_5678);
    rd_chk("mcause_ro", CSR_MCAUSE, 32'd0);
    commit(3'd5, CSR_MEPC, 32'h1234_5677);
    push("csrrwi_mepc", SEL_MEPC, 32'h1234_5674);
    drain();
    commit(3'd4, CSR_MTVEC, 32'hFFFF_FFFF);
    push("f3_4_ignored", SEL_MTVEC, 32'h0000_1000);
    drain();

    // Interrupt taken with MIE set
    commit(3'd2, CSR_MSTATUS, 32'd8);
    bus.INSTR_VALID = 1'b1;
    bus.NEXT_PC     = 32'h0000_0040;
    INTR            = 1'b1;
    wait_taken(20, n);
    meas = n;
    push("int_latency", SEL_MEAS, 32'd4);
    push("trap_mepc", SEL_MEPC, 32'h0000_0040);
    push("trap_mie", SEL_MIE, 32'd0);
    drain();
    rd_chk("trap_mstatus", CSR_MSTATUS, 32'h0000_0080);
    rd_chk("trap_mcause", CSR_MCAUSE, MCAUSE_EXT_INT);
    tick();
    push("taken_single", SEL_TAKEN, 32'd0);
    drain();
    INTR = 1'b0;
    idle_in();
    repeat (4) tick();

    // MRET restores MIE from MPIE
    commit(3'd0, 12'h302, 32'd0);
    push("mret_mie", SEL_MIE, 32'd1);
    drain();
    rd_chk("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);

    // Masked: two edges while MIE=0, commits flowing
    commit(3'd3, CSR_MSTATUS, 32'd8);
    bus.INSTR_VALID = 1'b1;
    INTR = 1'b1; repeat (3) tick();
    INTR = 1'b0; repeat (3) tick();
    INTR = 1'b1; repeat (3) tick();
    INTR = 1'b0;
    count_traps(20, n);
    meas = n;
    push("masked_no_trap", SEL_MEAS, 32'd0);
    drain();
    idle_in();
    bus.NEXT_PC = 32'h0000_0080;
    commit(3'd2, CSR_MSTATUS, 32'd8);
    push("enable_trap", SEL_TAKEN, 32'd1);
    drain();
    commit(3'd1, CSR_MTVEC, 32'h0000_2000);
    push("taken_ignores_mtvec", SEL_MTVEC, 32'h0000_1000);
    push("enable_trap_mepc", SEL_MEPC, 32'h0000_0080);
    push("enable_trap_mie", SEL_MIE, 32'd0);
    push("enable_taken_end", SEL_TAKEN, 32'd0);
    drain();
    rd_chk("enable_trap_mpie", CSR_MSTATUS, 32'h0000_0080);
    commit(3'd2, CSR_MSTATUS, 32'd8);
    bus.INSTR_VALID = 1'b1;
    count_traps(10, n);
    meas = n;
    push("edges_merged", SEL_MEAS, 32'd0);
    drain();

    // Reset in the TAKEN cycle, INTR held high throughout
    INTR = 1'b1;
    wait_taken(20, n);
    meas = n;
    push("rst_trap_latency", SEL_MEAS, 32'd4);
    drain();
    RST = 1'b1;
    idle_in();
    tick();
    RST = 1'b0;
    push("rst_mid_taken", SEL_TAKEN, 32'd0);
    push("rst_mid_mie", SEL_MIE, 32'd0);
    push("rst_mid_mtvec", SEL_MTVEC, RSTV);
    drain();
    count_traps(8, n);
    meas = n;
    push("rst_refill_masked", SEL_MEAS, 32'd0);
    drain();
    commit(3'd2, CSR_MSTATUS, 32'd8);
    push("rst_refill_trap", SEL_TAKEN, 32'd1);
    drain();
    tick();
    commit(3'd2, CSR_MSTATUS, 32'd8);
    bus.INSTR_VALID = 1'b1;
    count_traps(10, n);
    meas = n;
    push("rst_single_trap", SEL_MEAS, 32'd0);
    drain();
    INTR = 1'b0;
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
